// File: rtl/step_dir_gen_if.sv
// Move-command channel between a command source (firmware/SPI block) and
// the step/dir sequencer: valid/ready handshake carrying one move.
interface step_dir_gen_if #(
  parameter int COUNT_W  = 16,
  parameter int PERIOD_W = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [COUNT_W-1:0]  cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (output cmd_valid, cmd_dir, cmd_steps, cmd_period, input cmd_ready);
  modport slave  (input cmd_valid, cmd_dir, cmd_steps, cmd_period, output cmd_ready);
endinterface

// File: rtl/step_dir_gen.sv
// Motion-command sequencer for the microstepper core. Moves are queued in a
// one-entry pending buffer, then played out as step pulses with a fixed high
// time, a guaranteed direction-setup gap, and a signed absolute position.
module step_dir_gen #(
  parameter int COUNT_W  = 16,
  parameter int PERIOD_W = 16,
  parameter int PULSE_W  = 8,
  parameter int POS_W    = 32
) (
  input  logic               clk,
  input  logic               resetn,
  step_dir_gen_if.slave      cmd,
  input  logic [PULSE_W-1:0] cfg_pulse_width,
  input  logic [PULSE_W-1:0] cfg_dir_setup,
  input  logic               abort,
  output logic               step,
  output logic               dir,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic [POS_W-1:0]   position
);
  // Counter must hold both a full period and pulse width + 1.
  localparam int CNT_W = (PERIOD_W > PULSE_W) ? PERIOD_W : PULSE_W + 1;
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] COUNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]   POS_ZERO   = {POS_W{1'b0}};
  localparam logic [POS_W-1:0]   POS_ONE    = {{(POS_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    HIGH  = 3'd3,
    LOW   = 3'd4
  } state_t;

  state_t              state_r, state_nx;
  logic                pend_full_r;
  logic                pend_dir_r;
  logic [COUNT_W-1:0]  pend_steps_r;
  logic [PERIOD_W-1:0] pend_period_r;
  logic                act_dir_r;
  logic [COUNT_W-1:0]  rem_r, rem_nx;
  logic [CNT_W-1:0]    cnt_r, cnt_nx;
  logic [CNT_W-1:0]    pw_r, per_r;
  logic                abort_hold_r, abort_hold_nx;
  logic                dir_r, dir_nx;
  logic                step_r, done_r, done_nx, enable_r;
  logic [POS_W-1:0]    pos_r;
  logic                accept_s, take_s, rise_s, busy_s;
  logic [CNT_W-1:0]    pw_eff_s, per_eff_s, pw_m1_s;

  assign cmd.cmd_ready = resetn & ~pend_full_r & ~abort;
  assign accept_s      = cmd.cmd_valid & cmd.cmd_ready;
  assign busy_s        = (state_r != IDLE) | pend_full_r;

  // Effective pulse width / period: pulse at least 1 cycle, low time at least 1 cycle.
  assign pw_eff_s  = (cfg_pulse_width == {PULSE_W{1'b0}}) ? CNT_ONE : CNT_W'(cfg_pulse_width);
  assign per_eff_s = (CNT_W'(pend_period_r) > pw_eff_s) ? CNT_W'(pend_period_r) : (pw_eff_s + CNT_ONE);
  assign pw_m1_s   = pw_r - CNT_ONE;

  // Pending buffer: filled by a handshake, emptied by LOAD, flushed by abort.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_full_r   <= 1'b0;
      pend_dir_r    <= 1'b0;
      pend_steps_r  <= COUNT_ZERO;
      pend_period_r <= {PERIOD_W{1'b0}};
    end else if (abort) begin
      pend_full_r   <= 1'b0;
    end else if (accept_s) begin
      pend_full_r   <= 1'b1;
      pend_dir_r    <= cmd.cmd_dir;
      pend_steps_r  <= cmd.cmd_steps;
      pend_period_r <= cmd.cmd_period;
    end else if (take_s) begin
      pend_full_r   <= 1'b0;
    end else begin
      pend_full_r   <= pend_full_r;
    end
  end

  // Next-state and datapath-update decisions for the move sequencer.
  always_comb begin
    state_nx      = state_r;
    cnt_nx        = cnt_r;
    rem_nx        = rem_r;
    dir_nx        = dir_r;
    done_nx       = 1'b0;
    take_s        = 1'b0;
    rise_s        = 1'b0;
    abort_hold_nx = abort_hold_r;
    case (state_r)
      IDLE: begin
        abort_hold_nx = 1'b0;
        if (pend_full_r && !abort) begin
          state_nx = LOAD;
          take_s   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (rem_r == COUNT_ZERO) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if ((act_dir_r != dir_r) && (cfg_dir_setup != {PULSE_W{1'b0}})) begin
          dir_nx   = act_dir_r;
          state_nx = SETUP;
          cnt_nx   = CNT_W'(cfg_dir_setup) - CNT_ONE;
        end else begin
          dir_nx   = act_dir_r;
          state_nx = HIGH;
          rise_s   = 1'b1;
          cnt_nx   = pw_m1_s;
        end
      end
      SETUP: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_nx = HIGH;
          rise_s   = 1'b1;
          cnt_nx   = pw_m1_s;
        end else begin
          cnt_nx   = cnt_r - CNT_ONE;
        end
      end
      HIGH: begin
        // A started pulse always runs its full width; abort is remembered.
        if (cnt_r == CNT_ZERO) begin
          if (abort || abort_hold_r) begin
            state_nx      = IDLE;
            abort_hold_nx = 1'b0;
          end else begin
            state_nx = LOW;
            cnt_nx   = per_r - pw_r - CNT_ONE;
          end
        end else begin
          cnt_nx        = cnt_r - CNT_ONE;
          abort_hold_nx = abort_hold_r | abort;
        end
      end
      LOW: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          if (rem_r > COUNT_ONE) begin
            rem_nx   = rem_r - COUNT_ONE;
            state_nx = HIGH;
            rise_s   = 1'b1;
            cnt_nx   = pw_m1_s;
          end else begin
            rem_nx  = COUNT_ZERO;
            done_nx = 1'b1;
            if (pend_full_r) begin
              state_nx = LOAD;
              take_s   = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end
        end else begin
          cnt_nx = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register, active-move registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      rem_r        <= COUNT_ZERO;
      act_dir_r    <= 1'b0;
      pw_r         <= CNT_ONE;
      per_r        <= CNT_ZERO;
      abort_hold_r <= 1'b0;
      dir_r        <= 1'b0;
      step_r       <= 1'b0;
      done_r       <= 1'b0;
      enable_r     <= 1'b0;
      pos_r        <= POS_ZERO;
    end else begin
      state_r      <= state_nx;
      cnt_r        <= cnt_nx;
      abort_hold_r <= abort_hold_nx;
      dir_r        <= dir_nx;
      step_r       <= (state_nx == HIGH);
      done_r       <= done_nx;
      enable_r     <= busy_s;
      if (take_s) begin
        rem_r     <= pend_steps_r;
        act_dir_r <= pend_dir_r;
        pw_r      <= pw_eff_s;
        per_r     <= per_eff_s;
      end else begin
        rem_r     <= rem_nx;
      end
      if (rise_s) begin
        pos_r <= act_dir_r ? (pos_r + POS_ONE) : (pos_r - POS_ONE);
      end else begin
        pos_r <= pos_r;
      end
    end
  end

  assign step     = step_r;
  assign dir      = dir_r;
  assign enable   = enable_r;
  assign busy     = busy_s;
  assign done     = done_r;
  assign position = pos_r;
endmodule

// File: tb/tb_step_dir_gen.sv
// Self-checking bench for step_dir_gen: directed scenarios plus randomized
// move sequences compared per cycle against a timeline model of the moves.
module tb_step_dir_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [7:0]  cfg_pw, cfg_setup;
  logic        abort;
  logic        step, dir, enable, busy, done;
  logic [31:0] position;
  logic        w_step, w_dir, w_enable, w_busy, w_done;
  logic [3:0]  w_pos;

  step_dir_gen_if #(.COUNT_W(16), .PERIOD_W(16)) cmd_if ();
  step_dir_gen_if #(.COUNT_W(16), .PERIOD_W(16)) w_if ();

  step_dir_gen #(.COUNT_W(16), .PERIOD_W(16), .PULSE_W(8), .POS_W(32)) dut (
    .clk(clk), .resetn(resetn), .cmd(cmd_if), .cfg_pulse_width(cfg_pw),
    .cfg_dir_setup(cfg_setup), .abort(abort), .step(step), .dir(dir),
    .enable(enable), .busy(busy), .done(done), .position(position));

  // Narrow position counter instance to exercise two's-complement wrap.
  step_dir_gen #(.COUNT_W(16), .PERIOD_W(16), .PULSE_W(8), .POS_W(4)) dut_w (
    .clk(clk), .resetn(resetn), .cmd(w_if), .cfg_pulse_width(8'd1),
    .cfg_dir_setup(8'd0), .abort(1'b0), .step(w_step), .dir(w_dir),
    .enable(w_enable), .busy(w_busy), .done(w_done), .position(w_pos));

  int checks = 0;
  int errors = 0;

  // Model of the moves: command list plus derived timeline (edge indices).
  int   nm, pw_m, pos_m;
  logic dir_m;
  int   m_dir[3], m_steps[3], m_pin[3], m_per[3];
  int   ta[3], tl[3], tf[3], te[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_move(input int i, input int d, input int s, input int p);
    m_dir[i] = d; m_steps[i] = s; m_pin[i] = p;
  endtask

  // Timeline: accept edge A, load edge L, first rise F, completion edge E.
  task automatic plan(input int pw_cfg, input int setup);
    logic dcur;
    dcur = dir_m;
    pw_m = (pw_cfg == 0) ? 1 : pw_cfg;
    for (int i = 0; i < nm; i++) begin
      m_per[i] = (m_pin[i] > pw_m) ? m_pin[i] : pw_m + 1;
      ta[i] = (i == 0) ? 0 : tl[i-1] + 1;
      tl[i] = (i > 0 && ta[i] < te[i-1]) ? te[i-1] : ta[i] + 1;
      if (m_steps[i] == 0) begin
        tf[i] = 0;
        te[i] = tl[i] + 1;
      end else begin
        tf[i] = tl[i] + 1 + ((m_dir[i][0] != dcur) ? setup : 0);
        te[i] = tf[i] + m_steps[i] * m_per[i];
        dcur  = m_dir[i][0];
      end
    end
  endtask

  task automatic model_at(input int t, output logic e_step, output logic e_done,
                          output logic e_busy, output logic e_ready,
                          output logic e_dir, output int e_pos);
    int k, r;
    e_step = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
    e_dir = dir_m; e_pos = pos_m;
    for (int i = 0; i < nm; i++) begin
      if (t == te[i]) e_done = 1'b1;
      if (t >= ta[i] && t < te[i]) e_busy = 1'b1;
      if (t >= ta[i] && t < tl[i]) e_ready = 1'b0;
      if (m_steps[i] > 0) begin
        if (t >= tl[i] + 1) e_dir = m_dir[i][0];
        if (t >= tf[i]) begin
          k = (t - tf[i]) / m_per[i];
          r = (k + 1 < m_steps[i]) ? k + 1 : m_steps[i];
          e_pos = m_dir[i][0] ? e_pos + r : e_pos - r;
          if (k < m_steps[i] && ((t - tf[i]) % m_per[i]) < pw_m) e_step = 1'b1;
        end
      end
    end
  endtask

  task automatic drive_cmd(input int j);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = m_dir[j][0];
    cmd_if.cmd_steps  = 16'(m_steps[j]);
    cmd_if.cmd_period = 16'(m_pin[j]);
  endtask

  // Plays nm queued moves and compares every output every cycle.
  task automatic run_scenario(input string name, input int pw_cfg, input int setup);
    logic e_step, e_done, e_busy, e_ready, e_dir, prev_busy;
    int   e_pos, tend, j;
    cfg_pw = 8'(pw_cfg); cfg_setup = 8'(setup);
    plan(pw_cfg, setup);
    tend = te[nm-1] + 3;
    drive_cmd(0);
    prev_busy = 1'b0;
    for (int t = 0; t <= tend; t++) begin
      @(posedge clk);
      #1;
      j = 0;
      for (int i = 0; i < nm; i++) if (ta[i] <= t) j++;
      if (j < nm) drive_cmd(j);
      else cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      model_at(t, e_step, e_done, e_busy, e_ready, e_dir, e_pos);
      check($sformatf("%s step@%0d", name, t), {31'd0, step}, {31'd0, e_step});
      check($sformatf("%s done@%0d", name, t), {31'd0, done}, {31'd0, e_done});
      check($sformatf("%s busy@%0d", name, t), {31'd0, busy}, {31'd0, e_busy});
      check($sformatf("%s enable@%0d", name, t), {31'd0, enable}, {31'd0, prev_busy});
      check($sformatf("%s ready@%0d", name, t), {31'd0, cmd_if.cmd_ready}, {31'd0, e_ready});
      check($sformatf("%s dir@%0d", name, t), {31'd0, dir}, {31'd0, e_dir});
      check($sformatf("%s pos@%0d", name, t), position, 32'(e_pos));
      prev_busy = e_busy;
    end
    model_at(tend, e_step, e_done, e_busy, e_ready, e_dir, e_pos);
    pos_m = e_pos;
    dir_m = e_dir;
  endtask

  initial begin
    int sgn;
    logic exp_step, exp_busy, exp_ready, prev_b;
    resetn = 1'b0; abort = 1'b0; cfg_pw = 8'd1; cfg_setup = 8'd0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_dir = 1'b0; cmd_if.cmd_steps = 16'd0; cmd_if.cmd_period = 16'd0;
    w_if.cmd_valid = 1'b0; w_if.cmd_dir = 1'b0; w_if.cmd_steps = 16'd0; w_if.cmd_period = 16'd0;
    pos_m = 0; dir_m = 1'b0;

    // Reset held for 4 edges
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst step", {31'd0, step}, 32'd0);
      check("rst dir", {31'd0, dir}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst enable", {31'd0, enable}, 32'd0);
      check("rst ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      check("rst pos", position, 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    check("rel ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("rel busy", {31'd0, busy}, 32'd0);

    // Directed scenarios
    nm = 1; set_move(0, 0, 3, 10); run_scenario("basic", 3, 5);
    check("basic final pos", position, 32'hFFFF_FFFD);
    nm = 1; set_move(0, 1, 2, 10); run_scenario("dirchg", 3, 5);
    check("dirchg final pos", position, 32'hFFFF_FFFF);
    nm = 1; set_move(0, 1, 3, 0);  run_scenario("clamp0", 0, 1);
    nm = 1; set_move(0, 0, 2, 4);  run_scenario("clamp6", 6, 2);
    nm = 3; set_move(0, 1, 2, 5); set_move(1, 1, 3, 6); set_move(2, 0, 2, 4);
    run_scenario("queue", 2, 3);
    nm = 2; set_move(0, 1, 0, 5); set_move(1, 0, 2, 3); run_scenario("zero", 1, 2);

    // Randomized move sequences
    for (int s = 0; s < 25; s++) begin
      nm = $urandom_range(1, 3);
      for (int i = 0; i < nm; i++)
        set_move(i, $urandom_range(0, 1),
                 ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4),
                 $urandom_range(0, 12));
      run_scenario($sformatf("rnd%0d", s), $urandom_range(0, 5), $urandom_range(0, 4));
    end

    // Abort during the 2nd cycle of a 4-cycle pulse with a move pending
    sgn = dir_m ? 1 : -1;
    cfg_pw = 8'd4; cfg_setup = 8'd0;
    nm = 2; set_move(0, dir_m, 3, 10); set_move(1, dir_m, 2, 5);
    drive_cmd(0);
    prev_b = 1'b0;
    for (int t = 0; t <= 20; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) drive_cmd(1);
      if (t == 2) cmd_if.cmd_valid = 1'b0;
      abort = (t == 3);
      @(negedge clk);
      exp_step  = (t >= 2 && t <= 5);
      exp_busy  = (t < 6);
      exp_ready = !(t == 0 || t == 2 || t == 3);
      check($sformatf("abort step@%0d", t), {31'd0, step}, {31'd0, exp_step});
      check($sformatf("abort busy@%0d", t), {31'd0, busy}, {31'd0, exp_busy});
      check($sformatf("abort enable@%0d", t), {31'd0, enable}, {31'd0, prev_b});
      check($sformatf("abort ready@%0d", t), {31'd0, cmd_if.cmd_ready}, {31'd0, exp_ready});
      check($sformatf("abort done@%0d", t), {31'd0, done}, 32'd0);
      check($sformatf("abort pos@%0d", t), position, 32'(pos_m + ((t >= 2) ? sgn : 0)));
      prev_b = exp_busy;
    end
    pos_m = pos_m + sgn;

    // Position wrap on the narrow instance: +7 then one more forward step
    w_if.cmd_valid = 1'b1; w_if.cmd_dir = 1'b1; w_if.cmd_steps = 16'd7; w_if.cmd_period = 16'd2;
    @(posedge clk); #1; w_if.cmd_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("wrap pre", {28'd0, w_pos}, 32'h7);
    w_if.cmd_valid = 1'b1; w_if.cmd_steps = 16'd1;
    @(posedge clk); #1; w_if.cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("wrap", {28'd0, w_pos}, 32'h8);

    // Reset in the middle of a pulse truncates it
    cfg_pw = 8'd3;
    nm = 1; set_move(0, dir_m, 3, 10); drive_cmd(0);
    @(posedge clk); #1; cmd_if.cmd_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("midrst step high", {31'd0, step}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst step", {31'd0, step}, 32'd0);
    check("midrst pos", position, 32'd0);
    check("midrst dir", {31'd0, dir}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst rel ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/step_dir_gen.md
Name: step_dir_gen

Overview:
- Motion-command sequencer that drives the step/dir/enable inputs of the microstepper core.
- Accepts move commands (direction, step count, step period) over a valid/ready handshake into a one-entry pending buffer.
- Emits step pulses with configurable width and direction-setup time, and tracks absolute position.
- Replaces free-running step stimulus: firmware or the SPI register block queues moves here.

Parameters:
- COUNT_W, 16, width of step-count field.
- PERIOD_W, 16, width of step-period field, in clk cycles.
- PULSE_W, 8, width of pulse-width and dir-setup config fields.
- POS_W, 32, width of signed position counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  pending buffer empty and abort low.
- cmd_dir  in  1  direction of move (1 = forward).
- cmd_steps  in  COUNT_W  number of step pulses.
- cmd_period  in  PERIOD_W  rising-edge-to-rising-edge step period.
- cfg_pulse_width  in  PULSE_W  step high time, in cycles.
- cfg_dir_setup  in  PULSE_W  cycles between a dir change and the next step rise.
- abort  in  1  flush all moves.
- step  out  1  step pulse to microstepper.
- dir  out  1  direction to microstepper.
- enable  out  1  registered copy of busy (driver enable).
- busy  out  1  move active or pending.
- done  out  1  one-cycle pulse when a move completes normally.
- position  out  POS_W  signed step count.

Behaviour:
- Reset (resetn low at a clk edge):
  - step=0, dir=0, enable=0, busy=0, done=0, position=0.
  - pending buffer empty; state IDLE.
  - cmd_ready=0 while resetn is low.
- Handshake:
  - cmd_ready = pending empty AND NOT abort.
  - A transfer occurs on any edge where cmd_valid&cmd_ready; that edge fills pending.
  - The command is held in pending until the FSM loads it.
- Effective values:
  - pw = max(cfg_pulse_width, 1).
  - per = max(cmd_period, pw+1).
  - Both are latched at LOAD; config changes mid-move take effect at the next LOAD.
- FSM states: IDLE, LOAD, SETUP, HIGH, LOW.
  - IDLE: if pending is full, go to LOAD next edge; pending moves into the active registers and clears, so cmd_ready rises.
  - LOAD, steps==0: done=1 for one cycle, go to IDLE, dir unchanged.
  - LOAD, cmd_dir != dir: dir<=cmd_dir; go to SETUP for cfg_dir_setup cycles, or straight to HIGH if cfg_dir_setup==0.
  - LOAD, dir matches: go to HIGH.
  - HIGH: step=1 for exactly pw cycles.
    - position += 1 if dir=1, else -= 1, on the edge step rises.
    - Wraps two's-complement.
  - LOW: step=0 for per-pw cycles, then decrement remaining.
    - remaining>0: go to HIGH.
    - remaining==0 and pending full: done=1 this cycle, go to LOAD.
    - remaining==0 and pending empty: done=1, go to IDLE.
- Latency: with same dir and no wait, step rises 2 edges after the accepting edge (accept → IDLE→LOAD → HIGH).
- Back-to-back commands: the gap from the last step rise of move N to the first rise of move N+1 is per+1 cycles (same dir), plus cfg_dir_setup if dir changes.
- busy = state!=IDLE OR pending full. enable follows busy one cycle later.
- Abort:
  - Pending is cleared on the edge abort is sampled high.
  - If in HIGH, step finishes its full pw (a pulse is never truncated), then the FSM goes to IDLE.
  - From any other state, the FSM goes to IDLE next edge.
  - No done is asserted; position is kept.
  - A command offered while abort=1 is not accepted.
- Simultaneous: a cmd transfer can occur on the same edge the FSM loads from pending; the new command refills pending.
- Reset mid-move: step drops to 0 immediately on the reset edge; a truncated pulse is acceptable only under reset.

Test Plan:
- Reset:
  - Stimulus: hold resetn low 4 cycles, then release.
  - Required: step=0, dir=0, position=0, busy=0 during reset; cmd_ready=1 on the first cycle after release.
- Basic move:
  - Stimulus: dir=0 at rest; cmd dir=0, steps=3, period=10, pw=3.
  - Required: 3 pulses, each 3 cycles high, rises 10 cycles apart; first rise 2 edges after accept; position=-3; done pulses once, 7 cycles after the last rise ends its LOW.
- Dir change:
  - Stimulus: after the previous move, cmd dir=1, steps=2, setup=5.
  - Required: dir rises at LOAD; first step rises exactly 5 cycles later; position returns to -1.
- Clamping:
  - Stimulus: pw=0, period=0.
  - Required: pulses of 1 cycle high, period 2.
  - Stimulus: pw=6, period=4.
  - Required: period 7.
- Queueing:
  - Stimulus: offer 3 commands back-to-back with cmd_valid held.
  - Required: cmd_ready drops after the second is accepted; the third is accepted only when the first completes; no missing steps; 3 done pulses.
- Abort and wrap:
  - Stimulus: abort during the 2nd cycle of a pw=4 pulse.
  - Required: pulse still lasts 4 cycles, no done, pending flushed.
  - Stimulus: preload position to 0x7FFFFFFF via steps, then one forward step.
  - Required: position wraps to 0x80000000.
